// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM peripheral slice.
package pwm_pkg;

    // Number of chip output channels driven by the peripheral.
    localparam int NUM_CH = 16;

    // Width of the shared PWM period counter.
    localparam int CNT_W = 8;

    // Last PWM counter value before the wrap back to 0.
    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    // Duty value that forces a constant-high output instead of 255/256.
    localparam logic [CNT_W-1:0] DUTY_FULL = 8'hFF;

    // Bits needed to hold a prescale count of 0..prescale-1 (at least 1 bit).
    function automatic int prescale_width(input int prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

endpackage : pwm_pkg

// File: rtl/pwm_if.sv
// Register-to-peripheral bundle: configuration from the SPI register block
// in, registered channel outputs and the period marker back out.
interface pwm_if;
    import pwm_pkg::*;

    logic [7:0]        en_reg_out_7_0;
    logic [7:0]        en_reg_out_15_8;
    logic [7:0]        en_reg_pwm_7_0;
    logic [7:0]        en_reg_pwm_15_8;
    logic [CNT_W-1:0]  pwm_duty_cycle;
    logic [NUM_CH-1:0] out;
    logic              period_start;

    // Register block side: owns the configuration, observes the outputs.
    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out,
        input  period_start
    );

    // Peripheral side: consumes the configuration, drives the outputs.
    modport slave (
        input  en_reg_out_7_0,
        input  en_reg_out_15_8,
        input  en_reg_pwm_7_0,
        input  en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out,
        output period_start
    );

endinterface : pwm_if

// File: rtl/pwm_tick_gen.sv
// Prescaler: emits a one-clock tick every PRESCALE system clocks.
module pwm_tick_gen
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 3000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            PRE_W    = prescale_width(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_cnt;

    // The tick is the terminal count itself, so PRESCALE=1 ticks every clock.
    assign tick = (pre_cnt == PRE_LAST);

    // Count 0..PRESCALE-1 and return to 0 on the tick.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

endmodule : pwm_tick_gen

// File: rtl/pwm_peripheral.sv
// PWM peripheral: one shared prescaled 8-bit PWM waveform, a duty shadow
// that only updates at the period wrap, and 16 registered channel outputs
// gated by per-channel output and PWM enables.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 3000
) (
    input logic clk,
    input logic rst,
    pwm_if.slave bus
);

    logic              tick;
    logic              wrap;
    logic              pwm_level;
    logic [CNT_W-1:0]  pwm_cnt;
    logic [CNT_W-1:0]  duty_sh;
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] en_pwm;
    logic [NUM_CH-1:0] out_d;
    logic [NUM_CH-1:0] out_q;
    logic              period_start_q;

    pwm_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Enables are already in the clk domain and take effect unshadowed.
    assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

    // The wrap is the tick that moves the counter from 255 to 0.
    assign wrap = tick && (pwm_cnt == CNT_MAX);

    // Shared period counter; wraps naturally, all channels stay phase-aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + CNT_W'(1);
        end
    end

    // Duty shadow loads only at the wrap so a period is never cut or stretched.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_sh <= '0;
        end else if (wrap) begin
            duty_sh <= bus.pwm_duty_cycle;
        end
    end

    // 255 is forced fully on rather than 255/256; 0 falls out as always off.
    assign pwm_level = (duty_sh == DUTY_FULL) | (pwm_cnt < duty_sh);

    // Per-channel select: disabled -> 0, static -> 1, PWM -> shared level.
    always_comb begin
        out_d = en_out & (~en_pwm | {NUM_CH{pwm_level}});
    end

    // Register the channel outputs and the period marker together.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            out_q          <= out_d;
            period_start_q <= wrap;
        end
    end

    assign bus.out          = out_q;
    assign bus.period_start = period_start_q;

endmodule : pwm_peripheral
